// File: rtl/vga_pos_scheduler.sv
// Frame-synchronous position scheduler for the VGA ramIn1/ramIn2 inputs.
// CPU writes land in shadow registers and are committed at vertical-blank start.
module vga_pos_scheduler #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned X_MAX     = 640,
   parameter int unsigned STEP      = 1,
   parameter int unsigned FRAME_DIV = 1,
   parameter int unsigned POS2_INIT = 250
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             vsync,
   input  logic             cpuReq,
   input  logic             cpuSel,
   input  logic [WIDTH-1:0] cpuData,
   output logic             cpuAck,
   input  logic             animEn,
   output logic [WIDTH-1:0] pos1,
   output logic [WIDTH-1:0] pos2,
   output logic             frameStart,
   output logic             busy
);

   localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
   localparam logic [WIDTH:0]   WRAP_AT  = (WIDTH+1)'(X_MAX - STEP);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMMIT = 2'd1,
      ANIM   = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   shadow1;
   logic [WIDTH-1:0]   shadow2;
   logic               valid1;
   logic               valid2;
   logic [CNT_W-1:0]   frameCnt;
   logic               vsyncD;
   logic               cpuWon;
   logic               vblankEdge;

   assign vblankEdge = vsyncD & ~vsync;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         pos1       <= '0;
         pos2       <= WIDTH'(POS2_INIT);
         cpuAck     <= 1'b0;
         frameStart <= 1'b0;
         busy       <= 1'b0;
         shadow1    <= '0;
         shadow2    <= '0;
         valid1     <= 1'b0;
         valid2     <= 1'b0;
         frameCnt   <= '0;
         vsyncD     <= 1'b1;
         cpuWon     <= 1'b0;
      end else begin
         vsyncD <= vsync;
         case (state)
            IDLE: begin
               // Outputs are registered, so COMMIT's flags are raised on entry.
               if (vblankEdge) begin
                  state      <= COMMIT;
                  frameStart <= 1'b1;
                  busy       <= 1'b1;
                  cpuAck     <= 1'b0;
               end else if (cpuReq && !cpuAck) begin
                  cpuAck <= 1'b1;
                  if (cpuSel) begin
                     shadow2 <= cpuData;
                     valid2  <= 1'b1;
                  end else begin
                     shadow1 <= cpuData;
                     valid1  <= 1'b1;
                  end
               end else begin
                  cpuAck <= 1'b0;
               end
            end
            COMMIT: begin
               frameStart <= 1'b0;
               cpuAck     <= 1'b0;
               if (valid1) begin
                  pos1   <= shadow1;
                  cpuWon <= 1'b1;
               end else begin
                  cpuWon <= 1'b0;
               end
               if (valid2)
                  pos2 <= shadow2;
               valid1 <= 1'b0;
               valid2 <= 1'b0;
               // Counter holds at its last value; ANIM clears it after a step.
               if (frameCnt != CNT_LAST)
                  frameCnt <= frameCnt + 1'b1;
               if (animEn && (frameCnt == CNT_LAST)) begin
                  state <= ANIM;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            ANIM: begin
               frameCnt <= '0;
               cpuAck   <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
               if (!cpuWon) begin
                  if ({1'b0, pos1} >= WRAP_AT)
                     pos1 <= '0;
                  else
                     pos1 <= pos1 + WIDTH'(STEP);
               end
            end
            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               frameStart <= 1'b0;
               cpuAck     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_pos_scheduler.sv
// Directed bench for vga_pos_scheduler: handshake, commit timing, animation wrap, reset.
module tb_vga_pos_scheduler;

   localparam int unsigned W = 16;

   logic         clk;
   logic         resetN;
   logic         vsync;
   logic         cpuReq;
   logic         cpuSel;
   logic [W-1:0] cpuData;
   logic         cpuAck;
   logic         animEn;
   logic [W-1:0] pos1;
   logic [W-1:0] pos2;
   logic         frameStart;
   logic         busy;

   int errors;
   int checks;

   vga_pos_scheduler #(
      .WIDTH    (W),
      .X_MAX    (640),
      .STEP     (1),
      .FRAME_DIV(1),
      .POS2_INIT(250)
   ) dut (
      .clk       (clk),
      .resetN    (resetN),
      .vsync     (vsync),
      .cpuReq    (cpuReq),
      .cpuSel    (cpuSel),
      .cpuData   (cpuData),
      .cpuAck    (cpuAck),
      .animEn    (animEn),
      .pos1      (pos1),
      .pos2      (pos2),
      .frameStart(frameStart),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Post one value; leaves the bench at the negedge just after the ack pulse.
   task automatic cpu_write(input logic sel, input logic [W-1:0] data);
      bit acked;
      acked   = 1'b0;
      cpuReq  = 1'b1;
      cpuSel  = sel;
      cpuData = data;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cpuAck) begin
            acked = 1'b1;
            break;
         end
      end
      check("ack_seen", {31'd0, acked}, 32'd1);
      cpuReq = 1'b0;
      @(negedge clk);
      check("ack_single", {31'd0, cpuAck}, 32'd0);
   endtask

   // Falling vsync for one cycle; returns at the negedge inside COMMIT (T+1).
   task automatic vblank();
      vsync = 1'b0;
      @(negedge clk);
      vsync = 1'b1;
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      resetN  = 1'b0;
      vsync   = 1'b1;
      cpuReq  = 1'b0;
      cpuSel  = 1'b0;
      cpuData = '0;
      animEn  = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;

      // 1: idle after reset
      check("rst_pos1", pos1, 0);
      check("rst_pos2", pos2, 250);
      check("rst_busy", busy, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("idle_frameStart", frameStart, 0);
         check("idle_ack", cpuAck, 0);
      end

      // 2: post pos2=100, commit timing
      cpu_write(1'b1, 16'd100);
      check("t0_pos2", pos2, 250);
      vblank();
      check("t1_frameStart", frameStart, 1);
      check("t1_busy", busy, 1);
      check("t1_pos2", pos2, 250);
      @(negedge clk);
      check("t2_pos2", pos2, 100);
      check("t2_frameStart", frameStart, 0);
      check("t2_busy", busy, 0);

      // 3: last write wins
      cpu_write(1'b0, 16'd7);
      cpu_write(1'b0, 16'd9);
      vblank();
      @(negedge clk);
      check("lastwin_pos1", pos1, 9);
      check("lastwin_pos2", pos2, 100);

      // 4: animation wrap 638 -> 639 -> 0 -> 1
      cpu_write(1'b0, 16'd638);
      animEn = 1'b1;
      vblank();
      @(negedge clk);
      check("anim_commit_pos1", pos1, 638);
      check("anim_commit_busy", busy, 1);
      @(negedge clk);
      check("anim_suppress_pos1", pos1, 638);
      check("anim_done_busy", busy, 0);
      vblank();
      @(negedge clk);
      check("anim_t2_pos1", pos1, 638);
      @(negedge clk);
      check("anim_step1", pos1, 639);
      vblank();
      repeat (2) @(negedge clk);
      check("anim_wrap", pos1, 0);
      vblank();
      repeat (2) @(negedge clk);
      check("anim_after_wrap", pos1, 1);

      // 5: CPU commit suppresses the step for that frame
      cpu_write(1'b0, 16'd50);
      vblank();
      @(negedge clk);
      check("cpu_win_t2", pos1, 50);
      @(negedge clk);
      check("cpu_win_t3", pos1, 50);
      vblank();
      repeat (2) @(negedge clk);
      check("cpu_win_next", pos1, 51);
      check("pos2_not_animated", pos2, 100);

      // 6: request in the edge cycle waits until back in IDLE
      animEn  = 1'b0;
      cpuReq  = 1'b1;
      cpuSel  = 1'b1;
      cpuData = 16'd77;
      vblank();
      check("edge_req_t1_ack", cpuAck, 0);
      check("edge_req_t1_fs", frameStart, 1);
      @(negedge clk);
      check("edge_req_t2_ack", cpuAck, 0);
      @(negedge clk);
      check("edge_req_t3_ack", cpuAck, 1);
      cpuReq = 1'b0;
      @(negedge clk);
      check("edge_req_ack_drop", cpuAck, 0);
      check("edge_req_pos2_pending", pos2, 100);

      // Reset during COMMIT drops the pending pos2=77
      vblank();
      check("pre_rst_commit", frameStart, 1);
      resetN = 1'b0;
      #1;
      check("midrst_frameStart", frameStart, 0);
      check("midrst_busy", busy, 0);
      check("midrst_pos1", pos1, 0);
      check("midrst_pos2", pos2, 250);
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      vblank();
      check("post_rst_commit", frameStart, 1);
      @(negedge clk);
      check("shadow_lost_pos2", pos2, 250);
      check("shadow_lost_pos1", pos1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
